// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: round-robin N-to-1 cache-bus arbiter that locks the grant through read refills.
// Define CACHE_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module cache_bus_arbiter #(
  parameter int channels_p = 4,
  parameter int block_width_p = 16,
  parameter int dma_data_width_p = 2,
  parameter int pkt_width_p = 96
) (
  input  logic                              clk_i,
  input  logic                              nreset_i,
  input  logic [channels_p-1:0]             cb_valid_i,
  input  logic [channels_p*pkt_width_p-1:0] cb_pkt_i,
  output logic [channels_p-1:0]             cb_yumi_o,
  output logic [channels_p-1:0]             cb_valid_o,
  output logic [dma_data_width_p*32-1:0]    cb_data_o,
  output logic                              mem_valid_o,
  output logic [pkt_width_p-1:0]            mem_pkt_o,
  input  logic                              mem_yumi_i,
  input  logic                              mem_valid_i,
  input  logic [dma_data_width_p*32-1:0]    mem_data_i
);
  localparam int beats_p = block_width_p / dma_data_width_p;
  localparam int ch_w = channels_p > 1 ? $clog2(channels_p) : 1;
  localparam int cnt_w = $clog2(beats_p) + 1;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  state_e state_q, state_d;
  logic [ch_w-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick;
  logic [cnt_w-1:0] beat_cnt_q, beat_cnt_d;
  logic [pkt_width_p-1:0] pkts [channels_p];
  logic accept;
  for (genvar g = 0; g < channels_p; g++) begin : g_pkt
    assign pkts[g] = cb_pkt_i[g*pkt_width_p +: pkt_width_p];
  end
  assign mem_pkt_o = pkts[grant_q];
  assign cb_data_o = mem_data_i;
`ifdef CACHE_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = '0;
    for (int i = channels_p - 1; i >= 0; i--)
      if (cb_valid_i[i]) pick = ch_w'(i);
  end
`else
  // descending scan so the smallest offset from rr_ptr wins
  always_comb begin
    pick = '0;
    for (int i = channels_p - 1; i >= 0; i--)
      if (cb_valid_i[(int'(rr_ptr_q) + i) % channels_p]) pick = ch_w'((int'(rr_ptr_q) + i) % channels_p);
  end
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    mem_valid_o = 1'b0;
    cb_yumi_o = '0;
    cb_valid_o = '0;
    accept = 1'b0;
    case (state_q)
      IDLE: if (|cb_valid_i) begin
        grant_d = pick;
        state_d = REQ;
      end
      REQ: begin
        mem_valid_o = cb_valid_i[grant_q];
        accept = mem_valid_o & mem_yumi_i;
        cb_yumi_o[grant_q] = accept;
        if (accept) begin
`ifndef CACHE_ARB_FIXED_PRIO_EN
          rr_ptr_d = (grant_q == ch_w'(channels_p - 1)) ? '0 : grant_q + 1'b1;
`endif
          state_d = mem_pkt_o[0] ? IDLE : RESP;
          beat_cnt_d = '0;
        end else if (!mem_valid_o) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        cb_valid_o[grant_q] = mem_valid_i;
        if (mem_valid_i) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == cnt_w'(beats_p - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: randomized scoreboard bench for cache_bus_arbiter with a transaction-level arbitration model.
module tb_cache_bus_arbiter;
  localparam int N = 4, BW = 16, DW = 2, PW = 96, BEATS = BW / DW;
  logic clk_i = 1'b0, nreset_i = 1'b0;
  logic [N-1:0] cb_valid_i = '0;
  logic [N*PW-1:0] cb_pkt_i = '0;
  logic [N-1:0] cb_yumi_o, cb_valid_o;
  logic [DW*32-1:0] cb_data_o, mem_data_i = '0;
  logic mem_valid_o, mem_yumi_i = 1'b0, mem_valid_i = 1'b0;
  logic [PW-1:0] mem_pkt_o;
  typedef struct { logic [N-1:0] vec; logic [PW-1:0] pkt; } req_t;
  typedef struct { logic [N-1:0] vec; logic [DW*32-1:0] data; } beat_t;
  req_t exp_req[$];
  beat_t exp_beat[$];
  req_t mon_r;
  beat_t mon_b;
  int checks = 0, errors = 0, rr = 0;

  cache_bus_arbiter #(.channels_p(N), .block_width_p(BW), .dma_data_width_p(DW), .pkt_width_p(PW)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .cb_valid_i(cb_valid_i), .cb_pkt_i(cb_pkt_i),
    .cb_yumi_o(cb_yumi_o), .cb_valid_o(cb_valid_o), .cb_data_o(cb_data_o),
    .mem_valid_o(mem_valid_o), .mem_pkt_o(mem_pkt_o), .mem_yumi_i(mem_yumi_i),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (mem_valid_o && mem_yumi_i) begin
      if (exp_req.size() == 0) chk("unexpected_accept", 128'(mem_valid_o), 128'(0));
      else begin
        mon_r = exp_req.pop_front();
        chk("yumi", 128'(cb_yumi_o), 128'(mon_r.vec));
        chk("mem_pkt", 128'(mem_pkt_o), 128'(mon_r.pkt));
      end
    end else chk("idle_yumi", 128'(cb_yumi_o), 128'(0));
    if (mem_valid_i && exp_beat.size() != 0) begin
      mon_b = exp_beat.pop_front();
      chk("beat_valid", 128'(cb_valid_o), 128'(mon_b.vec));
      chk("beat_data", 128'(cb_data_o), 128'(mon_b.data));
    end else chk("no_beat", 128'(cb_valid_o), 128'(0));
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [PW-1:0] rand_pkt(input logic wr);
    logic [PW-1:0] p;
    p = {$urandom, $urandom, $urandom};
    p[0] = wr;
    return p;
  endfunction

  task automatic set_req(input int c, input logic wr);
    cb_valid_i[c] = 1'b1;
    cb_pkt_i[c*PW +: PW] = rand_pkt(wr);
  endtask

  function automatic int pick_m();
    for (int o = 0; o < N; o++)
      if (cb_valid_i[(rr + o) % N]) return (rr + o) % N;
    return 0;
  endfunction

  // one arbitration from an IDLE cycle with requests pending, through acceptance and any refill
  task automatic serve(input int gap_at, input logic [N-1:0] late, input bit cont);
    int w;
    logic [PW-1:0] p;
    beat_t b;
    w = pick_m();
    p = cb_pkt_i[w*PW +: PW];
    step();
    chk("req_latency", 128'(mem_valid_o), 128'(1));
    repeat ($urandom_range(0, 2)) step();
    exp_req.push_back('{vec: N'(1) << w, pkt: p});
    mem_yumi_i = 1'b1;
    step();
    mem_yumi_i = 1'b0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
    rr = (w + 1) % N;
`endif
    cb_valid_i[w] = 1'b0;
    if (cont) set_req(w, 1'b1);
    for (int c = 0; c < N; c++)
      if (late[c] && !cb_valid_i[c]) set_req(c, 1'($urandom_range(0, 1)));
    if (!p[0]) begin
      for (int i = 0; i < BEATS; i++) begin
        mem_yumi_i = 1'($urandom_range(0, 1));
        if (i == gap_at || $urandom_range(0, 3) == 0) step();
        b.vec = N'(1) << w;
        b.data = {$urandom, $urandom};
        exp_beat.push_back(b);
        mem_valid_i = 1'b1;
        mem_data_i = b.data;
        step();
        mem_valid_i = 1'b0;
      end
    end
    mem_yumi_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * N && cb_valid_i != '0; i++) serve(-1, '0, 1'b0);
  endtask

  initial begin
    logic [PW-1:0] p0;
    logic [N-1:0] mask;
    beat_t b;
    int c;
    for (int k = 0; k < N; k++) cb_pkt_i[k*PW +: PW] = rand_pkt(1'b0);
    mem_data_i = {$urandom, $urandom};
    #2 mem_valid_i = 1'b1;
    #1;
    chk("rst_mem_valid", 128'(mem_valid_o), 128'(0));
    chk("rst_yumi", 128'(cb_yumi_o), 128'(0));
    chk("rst_cb_valid", 128'(cb_valid_o), 128'(0));
    chk("rst_mem_pkt", 128'(mem_pkt_o), 128'(cb_pkt_i[0 +: PW]));
    chk("rst_cb_data", 128'(cb_data_o), 128'(mem_data_i));
    #1 mem_valid_i = 1'b0;
    repeat (2) step();
    nreset_i = 1'b1;
    // round-robin with every channel holding writes
    for (int k = 0; k < N; k++) set_req(k, 1'b1);
    repeat (5) serve(-1, '0, 1'b1);
    drain();
    // single read on ch2 with a gap before beat 3
    set_req(2, 1'b0);
    serve(3, '0, 1'b0);
    // lock: ch0 and ch3 arrive during ch1's refill
    set_req(1, 1'b0);
    serve(-1, 4'b1001, 1'b0);
    drain();
    // spurious response beat while idle
    b.vec = '0;
    b.data = {$urandom, $urandom};
    exp_beat.push_back(b);
    mem_valid_i = 1'b1;
    mem_data_i = b.data;
    step();
    mem_valid_i = 1'b0;
    // withdrawn request
    c = $urandom_range(0, N - 1);
    set_req(c, 1'b0);
    step();
    chk("withdraw_req", 128'(mem_valid_o), 128'(1));
    cb_valid_i[c] = 1'b0;
    mem_yumi_i = 1'b1;
    #1 chk("withdraw_drop", 128'(mem_valid_o), 128'(0));
    step();
    mem_yumi_i = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 1'b1);
    drain();
    // randomized traffic
    repeat (40) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++)
        if (mask[k] && !cb_valid_i[k]) set_req(k, 1'($urandom_range(0, 1)));
      serve(-1, N'($urandom_range(0, (1 << N) - 1)), 1'b0);
    end
    drain();
    // reset in the middle of a ch0 refill
    set_req(0, 1'b0);
    p0 = cb_pkt_i[0 +: PW];
    step();
    chk("rst_txn_req", 128'(mem_valid_o), 128'(1));
    exp_req.push_back('{vec: N'(1), pkt: p0});
    mem_yumi_i = 1'b1;
    step();
    mem_yumi_i = 1'b0;
    cb_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      b.vec = N'(1);
      b.data = {$urandom, $urandom};
      exp_beat.push_back(b);
      mem_valid_i = 1'b1;
      mem_data_i = b.data;
      step();
      mem_valid_i = 1'b0;
    end
    mem_valid_i = 1'b1;
    mem_data_i = {$urandom, $urandom};
    #1 chk("pre_reset_beat", 128'(cb_valid_o), 128'(1));
    nreset_i = 1'b0;
    #1;
    chk("async_rst_cb_valid", 128'(cb_valid_o), 128'(0));
    chk("async_rst_mem_valid", 128'(mem_valid_o), 128'(0));
    chk("async_rst_yumi", 128'(cb_yumi_o), 128'(0));
    mem_valid_i = 1'b0;
    rr = 0;
    repeat (2) step();
    nreset_i = 1'b1;
    set_req(0, 1'b0);
    serve(2, '0, 1'b0);
    repeat (3) step();
    chk("req_queue_empty", 128'(exp_req.size()), 128'(0));
    chk("beat_queue_empty", 128'(exp_beat.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
